branch_resolve: RTL and testbench
=================================

Name: branch_resolve

Overview:
- Pipeline stage directly downstream of the signed comparator in the CPU execute path.
- Registers the comparator's gt/lt/eq flags with the branch opcode and PC, and decides taken/not-taken.
- Computes the redirect target and drives a fetch redirect pulse.
- Generates a multi-cycle flush window that squashes wrong-path instructions, and keeps saturating branch statistics.

Parameters:
AW, 16, PC/offset/target width in bits
FLUSH_DEPTH, 2, number of accepted input slots squashed after a taken branch (1..7)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
stall  input  1  pipeline hold; when 1 all state holds, except that redirect clears
in_valid  input  1  instruction present at stage input
br_op  input  3  000 none, 001 BEQ, 010 BNE, 011 BLT, 100 BGE, 101 BGT, 110 BLE, 111 JMP
gt  input  1  comparator greater-than (signed)
lt  input  1  comparator less-than (signed)
eq  input  1  comparator equal
pc  input  AW  PC of the branch instruction
offset  input  AW  branch offset, two's complement
out_valid  output  1  registered: stage holds a valid, non-squashed instruction
taken  output  1  registered branch decision
target  output  AW  registered pc+offset
redirect  output  1  single-cycle fetch redirect pulse
flush  output  1  high while the squash window is open
flag_err  output  1  sticky: a conditional branch saw non-one-hot flags
br_count  output  16  branches resolved (br_op != 000), saturating
taken_count  output  16  branches taken, saturating

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, flush counter 0, both counters 0, flag_err 0.
- Accept condition, evaluated at each rising edge with stall=0: acc = in_valid & (fcnt==0).
  - in_valid=1 while fcnt!=0 is a squash: out_valid<=0 and fcnt<=fcnt-1.
  - In an idle cycle (in_valid=0, stall=0), fcnt holds. Only accepted slots and squashes consume the window.
- Decision on an accepted instruction:
  - BEQ: eq. BNE: !eq. BLT: lt. BGE: gt|eq. BGT: gt. BLE: lt|eq. JMP: 1. none: 0.
  - Flags are legal only when exactly one of gt/lt/eq is 1. For a conditional op (001..110) with illegal flags: taken=0 and flag_err<=1.
  - JMP and none ignore the flags.
- Registered outputs on an accepted instruction (latency 1 cycle):
  - out_valid<=1, taken<=decision, target<=pc+offset.
  - The add is truncated to AW bits, so it wraps modulo 2^AW.
  - target is updated for every accepted instruction, taken or not.
- No accept and no stall: out_valid<=0, taken<=0. target holds.
- Taken branch accepted:
  - redirect<=1 for exactly the next cycle, then 0. It clears even if stall rises.
  - fcnt<=FLUSH_DEPTH; flush = (fcnt!=0).
- Stall=1: out_valid, taken, target, fcnt and the counters hold. In_valid is ignored (not squashed, not accepted).
- Counters:
  - br_count increments for each accepted br_op != 000.
  - taken_count increments for each accepted taken branch.
  - Both saturate at 16'hFFFF.
- flag_err is cleared only by reset.
- Reset asserted mid-window: flush drops immediately (asynchronous). No redirect follows deassertion.

Test Plan:
- Reset: rst_n=0 with in_valid=1 and JMP driven -> every output 0; after release, first edge gives out_valid=1, taken=1.
- BLT taken, AW=16: pc=16'h0010, offset=16'hFFF8, lt=1 -> next cycle out_valid=1, taken=1, target=16'h0008, redirect=1 for one cycle. Flush stays high until two in_valid slots are squashed. br_count=1, taken_count=1.
- BGE not taken with eq/gt sweep: {gt,lt,eq}=010 -> taken=0, no redirect, flush=0. {gt,lt,eq}=001 -> taken=1.
- Illegal flags: BEQ with {gt,lt,eq}=110 -> taken=0, flag_err=1 and stays 1 after further legal branches.
- Stall behaviour:
  - Taken branch accepted, then stall=1 for 3 cycles with in_valid=1 -> redirect lasts 1 cycle only; fcnt holds at 2; outputs hold.
  - After stall drops, two squashed slots, then the next in_valid is accepted.
- Wrap and saturation:
  - pc=16'hFFFE, offset=16'h0004 -> target=16'h0002.
  - Force 65537 accepted JMPs (or preload in simulation) -> br_count and taken_count stay at 16'hFFFF.

Source files
------------

// File: rtl/branch_resolve_if.sv
// Execute-stage branch resolution bus: comparator flags, branch op and PC in;
// decision, redirect, flush window and branch statistics out.
`timescale 1ns/1ps
interface branch_resolve_if #(
  parameter int unsigned AW = 16
);
  logic          stall;
  logic          in_valid;
  logic [2:0]    br_op;
  logic          gt;
  logic          lt;
  logic          eq;
  logic [AW-1:0] pc;
  logic [AW-1:0] offset;
  logic          out_valid;
  logic          taken;
  logic [AW-1:0] target;
  logic          redirect;
  logic          flush;
  logic          flag_err;
  logic [15:0]   br_count;
  logic [15:0]   taken_count;

  modport master (
    output stall, in_valid, br_op, gt, lt, eq, pc, offset,
    input  out_valid, taken, target, redirect, flush, flag_err, br_count, taken_count
  );

  modport slave (
    input  stall, in_valid, br_op, gt, lt, eq, pc, offset,
    output out_valid, taken, target, redirect, flush, flag_err, br_count, taken_count
  );
endinterface

// File: rtl/branch_resolve.sv
// Branch resolution stage: turns comparator flags plus branch op into a taken
// decision, fetch redirect pulse, wrong-path squash window and branch statistics.
`timescale 1ns/1ps
module branch_resolve #(
  parameter int unsigned AW          = 16,
  parameter int unsigned FLUSH_DEPTH = 2
) (
  input logic             clk,
  input logic             rst_n,
  branch_resolve_if.slave bus
);
  localparam int unsigned FW = 3;
  localparam int unsigned CW = 16;
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_BEQ  = 3'b001,
    OP_BNE  = 3'b010,
    OP_BLT  = 3'b011,
    OP_BGE  = 3'b100,
    OP_BGT  = 3'b101,
    OP_BLE  = 3'b110,
    OP_JMP  = 3'b111
  } br_op_e;

  logic [FW-1:0] fcnt;
  logic          acc_c;
  logic          legal_c;
  logic          is_cond_c;
  logic          hit_c;
  logic          decision_c;

  // Branch decision; conditional ops only trust one-hot comparator flags
  always_comb begin
    legal_c   = 1'b0;
    is_cond_c = 1'b1;
    hit_c     = 1'b0;
    case ({bus.gt, bus.lt, bus.eq})
      3'b100, 3'b010, 3'b001: legal_c = 1'b1;
      default:                legal_c = 1'b0;
    endcase
    case (bus.br_op)
      OP_BEQ:  hit_c = bus.eq;
      OP_BNE:  hit_c = ~bus.eq;
      OP_BLT:  hit_c = bus.lt;
      OP_BGE:  hit_c = bus.gt | bus.eq;
      OP_BGT:  hit_c = bus.gt;
      OP_BLE:  hit_c = bus.lt | bus.eq;
      default: is_cond_c = 1'b0;
    endcase
    decision_c = (bus.br_op == OP_JMP) | (is_cond_c & legal_c & hit_c);
  end

  assign acc_c     = ~bus.stall & bus.in_valid & (fcnt == '0);
  assign bus.flush = (fcnt != '0);

  // Stage registers, squash window and saturating statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid   <= 1'b0;
      bus.taken       <= 1'b0;
      bus.target      <= '0;
      bus.redirect    <= 1'b0;
      bus.flag_err    <= 1'b0;
      bus.br_count    <= '0;
      bus.taken_count <= '0;
      fcnt            <= '0;
    end else begin
      bus.redirect <= 1'b0;
      if (!bus.stall) begin
        if (acc_c) begin
          bus.out_valid <= 1'b1;
          bus.taken     <= decision_c;
          bus.target    <= bus.pc + bus.offset;
          if (bus.br_op != OP_NONE && bus.br_count != CNT_MAX) begin
            bus.br_count <= bus.br_count + CW'(1);
          end
          if (decision_c && bus.taken_count != CNT_MAX) begin
            bus.taken_count <= bus.taken_count + CW'(1);
          end
          if (is_cond_c && !legal_c) begin
            bus.flag_err <= 1'b1;
          end
          if (decision_c) begin
            bus.redirect <= 1'b1;
            fcnt         <= FW'(FLUSH_DEPTH);
          end
        end else begin
          bus.out_valid <= 1'b0;
          bus.taken     <= 1'b0;
          // an instruction arriving inside the window is squashed and uses up a slot
          if (bus.in_valid && fcnt != '0) begin
            fcnt <= fcnt - FW'(1);
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_branch_resolve.sv
// Bench for branch_resolve: directed scenarios plus randomized traffic checked
// against a behavioural model of the stage.
`timescale 1ns/1ps
module tb_branch_resolve;
  localparam int unsigned AW = 16;
  localparam int unsigned FD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  branch_resolve_if #(.AW(AW)) bif();
  branch_resolve #(.AW(AW), .FLUSH_DEPTH(FD)) dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  int checks = 0;
  int errors = 0;

  // behavioural model state
  int m_fcnt, m_br, m_tk, m_target;
  bit m_ov, m_tkn, m_redir, m_err;

  function automatic bit decide(input logic [2:0] op, input logic g, input logic l,
                                input logic e, output bit bad);
    int  n;
    bit  legal;
    n     = int'(g) + int'(l) + int'(e);
    legal = (n == 1);
    bad   = 1'b0;
    if (op == 3'd0) return 1'b0;
    if (op == 3'd7) return 1'b1;
    if (!legal) begin
      bad = 1'b1;
      return 1'b0;
    end
    case (op)
      3'd1:    return e;
      3'd2:    return !e;
      3'd3:    return l;
      3'd4:    return !l;
      3'd5:    return g;
      default: return !g;
    endcase
  endfunction

  task automatic model_reset();
    m_fcnt = 0; m_br = 0; m_tk = 0; m_target = 0;
    m_ov = 0; m_tkn = 0; m_redir = 0; m_err = 0;
  endtask

  task automatic model_step();
    bit d, bad;
    if (!rst_n) begin
      model_reset();
      return;
    end
    m_redir = 1'b0;
    if (bif.stall) return;
    if (bif.in_valid && m_fcnt == 0) begin
      d        = decide(bif.br_op, bif.gt, bif.lt, bif.eq, bad);
      m_ov     = 1'b1;
      m_tkn    = d;
      m_target = (int'(bif.pc) + int'(bif.offset)) % 65536;
      if (bif.br_op != 3'd0 && m_br < 65535) m_br++;
      if (d && m_tk < 65535) m_tk++;
      if (bad) m_err = 1'b1;
      if (d) begin
        m_redir = 1'b1;
        m_fcnt  = int'(FD);
      end
    end else begin
      m_ov  = 1'b0;
      m_tkn = 1'b0;
      if (bif.in_valid) m_fcnt--;
    end
  endtask

  task automatic drive(input bit st, input bit iv, input logic [2:0] op,
                       input logic [2:0] flags, input logic [15:0] p, input logic [15:0] o);
    bif.stall    = st;
    bif.in_valid = iv;
    bif.br_op    = op;
    {bif.gt, bif.lt, bif.eq} = flags;
    bif.pc       = p;
    bif.offset   = o;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(0, 0, 3'd0, 3'b000, 16'h0, 16'h0);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive(0, 1, 3'd7, 3'b000, 16'h0100, 16'h0020);
    tick();
    tick();
    checks++;
    if ({bif.out_valid, bif.taken, bif.redirect, bif.flush, bif.flag_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %05b want 00000",
               {bif.out_valid, bif.taken, bif.redirect, bif.flush, bif.flag_err});
    end
    checks++;
    if ({bif.target, bif.br_count, bif.taken_count} !== 48'h0) begin
      errors++;
      $display("FAIL reset_regs: got %h want 0", {bif.target, bif.br_count, bif.taken_count});
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bif.out_valid, bif.taken, bif.redirect, bif.flush, bif.flag_err} !== 5'b11110) begin
      errors++;
      $display("FAIL reset_first_jmp: got %05b want 11110",
               {bif.out_valid, bif.taken, bif.redirect, bif.flush, bif.flag_err});
    end
    checks++;
    if (bif.target !== 16'h0120) begin
      errors++;
      $display("FAIL reset_first_target: got %h want 0120", bif.target);
    end
  endtask

  task automatic test_blt_taken();
    do_reset();
    drive(0, 1, 3'd3, 3'b010, 16'h0010, 16'hFFF8);
    tick();
    checks++;
    if ({bif.out_valid, bif.taken, bif.redirect, bif.flush, bif.target} !== {4'b1111, 16'h0008}) begin
      errors++;
      $display("FAIL blt_taken: got ov/tk/rd/fl=%04b tgt=%h want 1111 0008",
               {bif.out_valid, bif.taken, bif.redirect, bif.flush}, bif.target);
    end
    checks++;
    if ({bif.br_count, bif.taken_count} !== {16'd1, 16'd1}) begin
      errors++;
      $display("FAIL blt_counts: got %0d/%0d want 1/1", bif.br_count, bif.taken_count);
    end
    drive(0, 1, 3'd1, 3'b001, 16'h0400, 16'h0004);
    tick();
    checks++;
    if ({bif.out_valid, bif.redirect, bif.flush} !== 3'b001) begin
      errors++;
      $display("FAIL blt_squash1: got ov/rd/fl=%03b want 001",
               {bif.out_valid, bif.redirect, bif.flush});
    end
    tick();
    checks++;
    if ({bif.out_valid, bif.flush} !== 2'b00) begin
      errors++;
      $display("FAIL blt_squash2: got ov/fl=%02b want 00", {bif.out_valid, bif.flush});
    end
    tick();
    checks++;
    if ({bif.out_valid, bif.taken, bif.target} !== {2'b11, 16'h0404}) begin
      errors++;
      $display("FAIL blt_after_window: got ov/tk=%02b tgt=%h want 11 0404",
               {bif.out_valid, bif.taken}, bif.target);
    end
  endtask

  task automatic test_bge_sweep();
    do_reset();
    drive(0, 1, 3'd4, 3'b010, 16'h1000, 16'h0010);
    tick();
    checks++;
    if ({bif.out_valid, bif.taken, bif.redirect, bif.flush} !== 4'b1000) begin
      errors++;
      $display("FAIL bge_lt: got ov/tk/rd/fl=%04b want 1000",
               {bif.out_valid, bif.taken, bif.redirect, bif.flush});
    end
    drive(0, 1, 3'd4, 3'b001, 16'h1000, 16'h0020);
    tick();
    checks++;
    if ({bif.out_valid, bif.taken, bif.redirect, bif.flush} !== 4'b1111) begin
      errors++;
      $display("FAIL bge_eq: got ov/tk/rd/fl=%04b want 1111",
               {bif.out_valid, bif.taken, bif.redirect, bif.flush});
    end
  endtask

  task automatic test_illegal_flags();
    do_reset();
    drive(0, 1, 3'd1, 3'b110, 16'h0020, 16'h0002);
    tick();
    checks++;
    if ({bif.out_valid, bif.taken, bif.redirect, bif.flag_err} !== 4'b1001) begin
      errors++;
      $display("FAIL illegal_beq: got ov/tk/rd/err=%04b want 1001",
               {bif.out_valid, bif.taken, bif.redirect, bif.flag_err});
    end
    drive(0, 1, 3'd2, 3'b001, 16'h0030, 16'h0002);
    tick();
    drive(0, 1, 3'd3, 3'b100, 16'h0040, 16'h0002);
    tick();
    checks++;
    if ({bif.flag_err, bif.taken, bif.br_count} !== {2'b10, 16'd3}) begin
      errors++;
      $display("FAIL illegal_sticky: got err/tk=%02b br=%0d want 10 3",
               {bif.flag_err, bif.taken}, bif.br_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive(0, 1, 3'd5, 3'b100, 16'h0200, 16'h0040);
    tick();
    checks++;
    if ({bif.redirect, bif.target} !== {1'b1, 16'h0240}) begin
      errors++;
      $display("FAIL stall_accept: got rd=%0b tgt=%h want 1 0240", bif.redirect, bif.target);
    end
    drive(1, 1, 3'd1, 3'b001, 16'h1111, 16'h1111);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({bif.redirect, bif.out_valid, bif.taken, bif.flush, bif.target} !== {4'b0111, 16'h0240}) begin
        errors++;
        $display("FAIL stall_hold%0d: got rd/ov/tk/fl=%04b tgt=%h want 0111 0240", i,
                 {bif.redirect, bif.out_valid, bif.taken, bif.flush}, bif.target);
      end
    end
    bif.stall = 1'b0;
    tick();
    tick();
    checks++;
    if ({bif.out_valid, bif.flush} !== 2'b00) begin
      errors++;
      $display("FAIL stall_squash: got ov/fl=%02b want 00", {bif.out_valid, bif.flush});
    end
    tick();
    checks++;
    if ({bif.out_valid, bif.taken, bif.target, bif.br_count, bif.taken_count} !==
        {2'b11, 16'h2222, 16'd2, 16'd2}) begin
      errors++;
      $display("FAIL stall_resume: got ov/tk=%02b tgt=%h br=%0d tk=%0d want 11 2222 2 2",
               {bif.out_valid, bif.taken}, bif.target, bif.br_count, bif.taken_count);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    drive(0, 1, 3'd0, 3'b111, 16'hFFFE, 16'h0004);
    tick();
    checks++;
    if ({bif.out_valid, bif.taken, bif.target, bif.br_count} !== {2'b10, 16'h0002, 16'd0}) begin
      errors++;
      $display("FAIL wrap_target: got ov/tk=%02b tgt=%h br=%0d want 10 0002 0",
               {bif.out_valid, bif.taken}, bif.target, bif.br_count);
    end
    drive(0, 0, 3'd7, 3'b000, 16'h5555, 16'h5555);
    tick();
    checks++;
    if ({bif.out_valid, bif.target} !== {1'b0, 16'h0002}) begin
      errors++;
      $display("FAIL idle_hold: got ov=%0b tgt=%h want 0 0002", bif.out_valid, bif.target);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(0, 1, 3'd7, 3'b000, 16'h0300, 16'h0010);
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bif.flush, bif.redirect, bif.out_valid} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_async: got fl/rd/ov=%03b want 000",
               {bif.flush, bif.redirect, bif.out_valid});
    end
    drive(0, 0, 3'd0, 3'b000, 16'h0, 16'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++;
    if ({bif.redirect, bif.flush} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_release: got rd/fl=%02b want 00", {bif.redirect, bif.flush});
    end
  endtask

  task automatic test_random();
    logic [52:0] got, exp;
    logic [2:0]  flags;
    int          a, b;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      a = int'($urandom_range(0, 6)) - 3;
      b = int'($urandom_range(0, 6)) - 3;
      flags = {a > b, a < b, a == b};
      if ($urandom_range(0, 9) == 0) flags = 3'($urandom_range(0, 7));
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)),
            flags, 16'($urandom), 16'($urandom));
      tick();
      got = {bif.out_valid, bif.taken, bif.redirect, bif.flush, bif.flag_err,
             bif.target, bif.br_count, bif.taken_count};
      exp = {m_ov, m_tkn, m_redir, m_fcnt != 0, m_err, 16'(m_target), 16'(m_br), 16'(m_tk)};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h want %h", n, got, exp);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(0, 1, 3'd3, 3'b100, 16'h0, 16'h0);
    for (int n = 0; n < 65537; n++) tick();
    checks++;
    if ({bif.br_count, bif.taken_count} !== {16'hFFFF, 16'h0}) begin
      errors++;
      $display("FAIL sat_br: got br=%h tk=%h want FFFF 0000", bif.br_count, bif.taken_count);
    end
    force bif.taken_count = 16'hFFFD;
    #1 release bif.taken_count;
    m_tk = 65533;
    for (int r = 0; r < 3; r++) begin
      drive(0, 1, 3'd7, 3'b000, 16'h0, 16'h0);
      tick();
      drive(0, 1, 3'd0, 3'b000, 16'h0, 16'h0);
      tick();
      tick();
      checks++;
      if ({bif.br_count, bif.taken_count} !== {16'hFFFF, 16'(m_tk)}) begin
        errors++;
        $display("FAIL sat_taken%0d: got br=%h tk=%h want FFFF %h", r,
                 bif.br_count, bif.taken_count, 16'(m_tk));
      end
    end
    checks++;
    if (bif.taken_count !== 16'hFFFF) begin
      errors++;
      $display("FAIL sat_taken_final: got %h want FFFF", bif.taken_count);
    end
  endtask

  initial begin
    model_reset();
    drive(0, 0, 3'd0, 3'b000, 16'h0, 16'h0);
    @(negedge clk);
    test_reset();
    test_blt_taken();
    test_bge_sweep();
    test_illegal_flags();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
